mem_responder: RTL

Memory-side responder for the processor's shared instruction/data memory port: receives a single-word read or write request (address, write data, write enable) over a req/ready handshake, inserts a configurable number of wait states, performs the access on an internal word array, and returns read data with a one-cycle ready pulse. It sits where the zero-latency shared memory sits today, adding wait-state behaviour so the processor's stall path can be exercised against a slow memory.

---
 rtl/mem_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Shared-memory responder with programmable wait states and a one-cycle ready pulse.
// Optional address checking is enabled by defining MEM_RESPONDER_ERR_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for req; capture we/a/wd and load the wait counter
// BUSY  | counting down wait states; perform the access at count 0
// DONE  | ready (and err) high for this one cycle, then back to IDLE
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wd_q;
    logic            bad_q;
    logic            bad;
    logic            capture;
    logic            access;
    logic [31:0]     mem [DEPTH_WORDS];

`ifdef MEM_RESPONDER_ERR_EN
    assign bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH_WORDS));
`else
    // Without checking, byte offset and high address bits are don't-cares (addresses wrap).
    logic unused_addr;
    assign unused_addr = ^{a[1:0], a[31:AW+2]};
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
            we_q  <= 1'b0;
            idx_q <= '0;
            wd_q  <= 32'd0;
            bad_q <= 1'b0;
            rd    <= 32'd0;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            ready <= access;
            err   <= access & bad_q;
            if (capture) begin
                we_q  <= we;
                idx_q <= a[AW+1:2];
                wd_q  <= wd;
                bad_q <= bad;
                cnt_q <= 4'(WAIT_CYCLES);
            end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // Write completions leave rd untouched; rejected reads return zero.
            if (access && !we_q) begin
                rd <= bad_q ? 32'd0 : mem[idx_q];
            end
        end
    end

    // Array has no reset; access is only possible out of BUSY, which reset clears.
    always_ff @(posedge clk) begin
        if (access && we_q && !bad_q) begin
            mem[idx_q] <= wd_q;
        end
    end

endmodule
